// File: rtl/fat32_pkg.sv
// fat32_pkg: shared FSM states, sector field offsets, partition types and error codes for the mount path
package fat32_pkg;
  typedef enum logic [3:0] {
    ST_IDLE, ST_REQ_MBR, ST_RX_MBR, ST_CHK_MBR, ST_REQ_BPB, ST_RX_BPB,
    ST_CHK_BPB, ST_CALC1, ST_CALC2, ST_DONE, ST_ERROR
  } state_t;
  typedef enum logic [2:0] {
    ERR_NONE, ERR_SD, ERR_MBR_SIG, ERR_PTYPE, ERR_BPB_SIG, ERR_SECT_SIZE, ERR_GEOMETRY, ERR_TIMEOUT
  } err_t;
  localparam logic [8:0] OFF_PTYPE = 9'h1C2;
  localparam logic [8:0] OFF_PLBA = 9'h1C6;
  localparam logic [8:0] OFF_SIG = 9'h1FE;
  localparam logic [8:0] OFF_BPS = 9'h00B;
  localparam logic [8:0] OFF_SPC = 9'h00D;
  localparam logic [8:0] OFF_RSV = 9'h00E;
  localparam logic [8:0] OFF_NFAT = 9'h010;
  localparam logic [8:0] OFF_FATLEN = 9'h024;
  localparam logic [8:0] OFF_ROOTCL = 9'h02C;
  localparam logic [7:0] PTYPE_FAT32_CHS = 8'h0B;
  localparam logic [7:0] PTYPE_FAT32_LBA = 8'h0C;
  localparam logic [15:0] SIG_BOOT = 16'hAA55;
  function automatic logic hit(input logic [8:0] idx, input logic [8:0] base, input logic [8:0] len);
    return idx >= base && idx - base < len;
  endfunction
  function automatic logic [1:0] lane(input logic [8:0] idx, input logic [8:0] base);
    return 2'(idx - base);
  endfunction
endpackage

// File: rtl/sector_rx_tracker.sv
// sector_rx_tracker: byte index, last-byte flag and inter-byte timeout for one streamed sector
module sector_rx_tracker
  import fat32_pkg::*;
#(
  parameter int TimeoutCycles = 1_000_000,
  parameter int TimeoutWidth = 20
) (
  input  logic       Clock,
  input  logic       sys_rst_n,
  input  logic       clear,
  input  logic       byte_valid,
  output logic [8:0] index,
  output logic       last,
  output logic       timeout
);
  logic [TimeoutWidth-1:0] idle;
  assign last = &index;
  // fires on the idle cycle that completes the allowed gap, so the error lands exactly TimeoutCycles after the last byte
  assign timeout = !clear && !byte_valid && idle == TimeoutWidth'(TimeoutCycles - 1);
  always_ff @(posedge Clock or negedge sys_rst_n)
    if (!sys_rst_n) begin
      index <= '0;
      idle <= '0;
    end else if (clear) begin
      index <= '0;
      idle <= '0;
    end else if (byte_valid) begin
      index <= index + 9'd1;
      idle <= '0;
    end else if (!timeout) idle <= idle + TimeoutWidth'(1);
endmodule

// File: rtl/fat32_mount_sequencer.sv
// fat32_mount_sequencer: reads MBR and BPB through the SD reader, validates them and derives FAT32 sector addresses
module fat32_mount_sequencer
  import fat32_pkg::*;
#(
  parameter int SectorBytes = 512,
  parameter int TimeoutCycles = 1_000_000,
  parameter int TimeoutWidth = 20
) (
  input  logic        Clock,
  input  logic        sys_rst_n,
  input  logic        MountStart,
  output logic        SdReadStart,
  output logic [31:0] SdReadSector,
  input  logic        SdBusy,
  input  logic        SdByteValid,
  input  logic [7:0]  SdByte,
  input  logic        SdError,
  output logic        MountBusy,
  output logic        Mounted,
  output logic        MountError,
  output logic [2:0]  ErrorCode,
  output logic [31:0] PartitionStartSector,
  output logic [31:0] FatStartSector,
  output logic [31:0] RootDirSector,
  output logic [7:0]  SectorsPerCluster,
  output logic [31:0] RootCluster
);
  state_t state, state_n;
  err_t err_n;
  logic read_n, rx, cap, start, last, timeout;
  logic [8:0] index;
  logic [15:0] sig, bps, rsv;
  logic [7:0] ptype, nfat;
  logic [31:0] fat_len;
  assign rx = state == ST_RX_MBR || state == ST_RX_BPB;
  assign cap = rx && SdByteValid && !SdError;
  assign MountBusy = !(state inside {ST_IDLE, ST_DONE, ST_ERROR});
  assign start = MountStart && !MountBusy;
  assign Mounted = state == ST_DONE;
  assign MountError = state == ST_ERROR;
  assign SdReadSector = (state == ST_REQ_BPB || state == ST_RX_BPB) ? PartitionStartSector : '0;
  sector_rx_tracker #(
    .TimeoutCycles(TimeoutCycles),
    .TimeoutWidth(TimeoutWidth)
  ) u_rx (
    .Clock(Clock),
    .sys_rst_n(sys_rst_n),
    .clear(!rx),
    .byte_valid(cap),
    .index(index),
    .last(last),
    .timeout(timeout)
  );
  always_ff @(posedge Clock or negedge sys_rst_n)
    if (!sys_rst_n) state <= ST_IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    err_n = ERR_NONE;
    read_n = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: state_n = MountStart ? ST_REQ_MBR : state;
      ST_REQ_MBR, ST_REQ_BPB: begin
        read_n = !SdBusy;
        state_n = SdBusy ? state : (state == ST_REQ_MBR ? ST_RX_MBR : ST_RX_BPB);
      end
      ST_RX_MBR, ST_RX_BPB: begin
        err_n = SdError ? ERR_SD : (timeout ? ERR_TIMEOUT : ERR_NONE);
        if (err_n != ERR_NONE) state_n = ST_ERROR;
        else if (SdByteValid && last) state_n = state == ST_RX_MBR ? ST_CHK_MBR : ST_CHK_BPB;
      end
      ST_CHK_MBR: begin
        err_n = sig != SIG_BOOT ? ERR_MBR_SIG :
                (ptype == PTYPE_FAT32_CHS || ptype == PTYPE_FAT32_LBA) ? ERR_NONE : ERR_PTYPE;
        state_n = err_n == ERR_NONE ? ST_REQ_BPB : ST_ERROR;
      end
      ST_CHK_BPB: begin
        err_n = sig != SIG_BOOT ? ERR_BPB_SIG :
                bps != 16'(SectorBytes) ? ERR_SECT_SIZE :
                (nfat == '0 || fat_len == '0 || SectorsPerCluster == '0) ? ERR_GEOMETRY : ERR_NONE;
        state_n = err_n == ERR_NONE ? ST_CALC1 : ST_ERROR;
      end
      ST_CALC1: state_n = ST_CALC2;
      ST_CALC2: state_n = ST_DONE;
      default: state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge Clock or negedge sys_rst_n)
    if (!sys_rst_n) begin
      SdReadStart <= 1'b0;
      ErrorCode <= '0;
      PartitionStartSector <= '0;
      FatStartSector <= '0;
      RootDirSector <= '0;
      SectorsPerCluster <= '0;
      RootCluster <= '0;
      sig <= '0;
      bps <= '0;
      rsv <= '0;
      ptype <= '0;
      nfat <= '0;
      fat_len <= '0;
    end else begin
      SdReadStart <= read_n;
      if (start) begin
        ErrorCode <= '0;
        PartitionStartSector <= '0;
        FatStartSector <= '0;
        RootDirSector <= '0;
        SectorsPerCluster <= '0;
        RootCluster <= '0;
        sig <= '0;
        bps <= '0;
        rsv <= '0;
        ptype <= '0;
        nfat <= '0;
        fat_len <= '0;
      end
      if (state_n == ST_ERROR && state != ST_ERROR) ErrorCode <= err_n;
      // both sectors end in the same boot signature, so one register serves both checks
      if (cap && hit(index, OFF_SIG, 9'd2)) sig[8*lane(index, OFF_SIG) +: 8] <= SdByte;
      if (cap && state == ST_RX_MBR) begin
        if (index == OFF_PTYPE) ptype <= SdByte;
        if (hit(index, OFF_PLBA, 9'd4)) PartitionStartSector[8*lane(index, OFF_PLBA) +: 8] <= SdByte;
      end
      if (cap && state == ST_RX_BPB) begin
        if (hit(index, OFF_BPS, 9'd2)) bps[8*lane(index, OFF_BPS) +: 8] <= SdByte;
        if (index == OFF_SPC) SectorsPerCluster <= SdByte;
        if (hit(index, OFF_RSV, 9'd2)) rsv[8*lane(index, OFF_RSV) +: 8] <= SdByte;
        if (index == OFF_NFAT) nfat <= SdByte;
        if (hit(index, OFF_FATLEN, 9'd4)) fat_len[8*lane(index, OFF_FATLEN) +: 8] <= SdByte;
        if (hit(index, OFF_ROOTCL, 9'd4)) RootCluster[8*lane(index, OFF_ROOTCL) +: 8] <= SdByte;
      end
      if (state == ST_CALC1) FatStartSector <= PartitionStartSector + {16'b0, rsv};
      if (state == ST_CALC2) RootDirSector <= FatStartSector + fat_len * {24'b0, nfat};
    end
endmodule

// File: tb/tb_fat32_mount_sequencer.sv
// tb_fat32_mount_sequencer: directed mount scenarios checked against hand-computed sector addresses and error codes
`timescale 1ns/1ps
module tb_fat32_mount_sequencer;
  localparam int TO = 64;
  logic Clock = 1'b0;
  logic sys_rst_n = 1'b0;
  logic MountStart = 1'b0;
  logic SdBusy = 1'b0;
  logic SdByteValid = 1'b0;
  logic SdError = 1'b0;
  logic [7:0] SdByte = 8'h00;
  logic SdReadStart, MountBusy, Mounted, MountError;
  logic [31:0] SdReadSector, PartitionStartSector, FatStartSector, RootDirSector, RootCluster;
  logic [7:0] SectorsPerCluster;
  logic [2:0] ErrorCode;
  logic [7:0] img [512];
  int compared = 0;
  int mismatched = 0;

  fat32_mount_sequencer #(.SectorBytes(512), .TimeoutCycles(TO), .TimeoutWidth(7)) dut (
    .Clock(Clock),
    .sys_rst_n(sys_rst_n),
    .MountStart(MountStart),
    .SdReadStart(SdReadStart),
    .SdReadSector(SdReadSector),
    .SdBusy(SdBusy),
    .SdByteValid(SdByteValid),
    .SdByte(SdByte),
    .SdError(SdError),
    .MountBusy(MountBusy),
    .Mounted(Mounted),
    .MountError(MountError),
    .ErrorCode(ErrorCode),
    .PartitionStartSector(PartitionStartSector),
    .FatStartSector(FatStartSector),
    .RootDirSector(RootDirSector),
    .SectorsPerCluster(SectorsPerCluster),
    .RootCluster(RootCluster)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at 2ms, required to finish");
    $fatal(1);
  end

  task automatic build_mbr(input logic [7:0] ptype, input logic [31:0] lba, input logic [7:0] sig1);
    for (int i = 0; i < 512; i++) img[i] = 8'(i * 7 + 3);
    img[9'h1C2] = ptype;
    {img[9'h1C9], img[9'h1C8], img[9'h1C7], img[9'h1C6]} = lba;
    img[510] = 8'h55;
    img[511] = sig1;
  endtask

  task automatic build_bpb(input logic [15:0] bps, input logic [7:0] spc, input logic [15:0] rsv,
                           input logic [7:0] nfat, input logic [31:0] flen, input logic [31:0] rcl,
                           input logic [7:0] sig1);
    for (int i = 0; i < 512; i++) img[i] = 8'(i * 5 + 1);
    {img[12], img[11]} = bps;
    img[13] = spc;
    {img[15], img[14]} = rsv;
    img[16] = nfat;
    {img[39], img[38], img[37], img[36]} = flen;
    {img[47], img[46], img[45], img[44]} = rcl;
    img[510] = 8'h55;
    img[511] = sig1;
  endtask

  task automatic send_sector(input int n, input int err_at, input int start_at);
    for (int i = 0; i < n; i++) begin
      SdByteValid = 1'b1;
      SdByte = img[i];
      SdError = (i == err_at);
      MountStart = (i == start_at);
      @(negedge Clock);
    end
    SdByteValid = 1'b0;
    SdError = 1'b0;
    MountStart = 1'b0;
  endtask

  task automatic start_mount();
    @(negedge Clock);
    MountStart = 1'b1;
    @(negedge Clock);
    MountStart = 1'b0;
  endtask

  task automatic wait_read(output logic [31:0] sec);
    bit got = 1'b0;
    sec = 'x;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge Clock);
      if (SdReadStart) begin
        got = 1'b1;
        sec = SdReadSector;
      end
    end
    compared++;
    if (!got) begin
      mismatched++;
      $display("FAIL read_wait: SdReadStart stayed 0 for 50 cycles, required 1");
    end
  endtask

  task automatic prep_bpb();
    logic [31:0] sec;
    start_mount();
    wait_read(sec);
    build_mbr(8'h0C, 32'h0000_2000, 8'hAA);
    send_sector(512, -1, -1);
    wait_read(sec);
  endtask

  task automatic run_nominal();
    prep_bpb();
    build_bpb(16'd512, 8'd8, 16'd32, 8'd2, 32'd961, 32'd2, 8'hAA);
    send_sector(512, -1, -1);
    repeat (3) @(negedge Clock);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge Clock);
    compared++;
    if ({SdReadStart, MountBusy, Mounted, MountError, ErrorCode, SdReadSector, PartitionStartSector,
         FatStartSector, RootDirSector, SectorsPerCluster, RootCluster} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: some output nonzero (Busy=%b Err=%b Part=%h), required all 0", MountBusy, MountError, PartitionStartSector);
    end
    sys_rst_n = 1'b1;
    repeat (3) @(negedge Clock);
    compared++;
    if (MountBusy !== 1'b0 || SdReadStart !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_idle: Busy=%b ReadStart=%b, required 0/0", MountBusy, SdReadStart);
    end
  endtask

  task automatic test_nominal();
    logic [31:0] sec;
    start_mount();
    compared++;
    if (MountBusy !== 1'b1) begin
      mismatched++;
      $display("FAIL nominal_busy: got %b, required 1", MountBusy);
    end
    wait_read(sec);
    compared++;
    if (sec !== 32'd0) begin
      mismatched++;
      $display("FAIL nominal_mbr_lba: got %0d, required 0", sec);
    end
    build_mbr(8'h0C, 32'h0000_2000, 8'hAA);
    send_sector(512, -1, 5);
    wait_read(sec);
    compared++;
    if (sec !== 32'd8192) begin
      mismatched++;
      $display("FAIL nominal_bpb_lba: got %0d, required 8192", sec);
    end
    build_bpb(16'd512, 8'd8, 16'd32, 8'd2, 32'd961, 32'd2, 8'hAA);
    send_sector(512, -1, -1);
    repeat (2) @(negedge Clock);
    compared++;
    if (Mounted !== 1'b0 || MountBusy !== 1'b1) begin
      mismatched++;
      $display("FAIL nominal_early: Mounted=%b Busy=%b two cycles after last byte, required 0/1", Mounted, MountBusy);
    end
    @(negedge Clock);
    compared++;
    if (Mounted !== 1'b1 || MountBusy !== 1'b0 || MountError !== 1'b0) begin
      mismatched++;
      $display("FAIL nominal_mounted: Mounted=%b Busy=%b Err=%b, required 1/0/0", Mounted, MountBusy, MountError);
    end
    compared++;
    if ({PartitionStartSector, FatStartSector, RootDirSector} !== {32'd8192, 32'd8224, 32'd10146}) begin
      mismatched++;
      $display("FAIL nominal_addrs: got %0d/%0d/%0d, required 8192/8224/10146", PartitionStartSector, FatStartSector, RootDirSector);
    end
    compared++;
    if (SectorsPerCluster !== 8'd8 || RootCluster !== 32'd2) begin
      mismatched++;
      $display("FAIL nominal_geom: spc=%0d root_cluster=%0d, required 8/2", SectorsPerCluster, RootCluster);
    end
  endtask

  task automatic test_busy();
    logic [31:0] sec;
    bit seen = 1'b0;
    SdBusy = 1'b1;
    start_mount();
    repeat (10) begin
      @(negedge Clock);
      if (SdReadStart) seen = 1'b1;
    end
    compared++;
    if (seen) begin
      mismatched++;
      $display("FAIL busy_hold: SdReadStart seen while SdBusy=1, required none");
    end
    SdBusy = 1'b0;
    @(negedge Clock);
    compared++;
    if (SdReadStart !== 1'b1 || SdReadSector !== 32'd0) begin
      mismatched++;
      $display("FAIL busy_release: start=%b sector=%0d, required 1/0", SdReadStart, SdReadSector);
    end
    @(negedge Clock);
    compared++;
    if (SdReadStart !== 1'b0) begin
      mismatched++;
      $display("FAIL busy_pulse_width: got %b one cycle later, required 0", SdReadStart);
    end
    build_mbr(8'h0C, 32'h0000_2000, 8'hAA);
    send_sector(512, -1, -1);
    wait_read(sec);
    compared++;
    if (sec !== 32'd8192) begin
      mismatched++;
      $display("FAIL busy_bpb_lba: got %0d, required 8192", sec);
    end
    build_bpb(16'd512, 8'd8, 16'd32, 8'd2, 32'd961, 32'd2, 8'hAA);
    send_sector(512, -1, -1);
    repeat (3) @(negedge Clock);
    compared++;
    if (Mounted !== 1'b1 || RootDirSector !== 32'd10146) begin
      mismatched++;
      $display("FAIL busy_mounted: Mounted=%b root=%0d, required 1/10146", Mounted, RootDirSector);
    end
  endtask

  task automatic test_mbr_errors();
    logic [31:0] sec;
    bit seen = 1'b0;
    start_mount();
    wait_read(sec);
    build_mbr(8'h0C, 32'h0000_2000, 8'hAB);
    send_sector(512, -1, -1);
    @(negedge Clock);
    compared++;
    if (MountError !== 1'b1 || ErrorCode !== 3'd2 || MountBusy !== 1'b0 || Mounted !== 1'b0) begin
      mismatched++;
      $display("FAIL mbr_sig: Err=%b code=%0d Busy=%b, required 1/2/0", MountError, ErrorCode, MountBusy);
    end
    repeat (20) begin
      @(negedge Clock);
      if (SdReadStart) seen = 1'b1;
    end
    compared++;
    if (seen) begin
      mismatched++;
      $display("FAIL mbr_sig_noread: second read issued, required none");
    end
    start_mount();
    wait_read(sec);
    build_mbr(8'h07, 32'h0000_2000, 8'hAA);
    send_sector(512, -1, -1);
    @(negedge Clock);
    compared++;
    if (MountError !== 1'b1 || ErrorCode !== 3'd3) begin
      mismatched++;
      $display("FAIL mbr_ptype: Err=%b code=%0d, required 1/3", MountError, ErrorCode);
    end
  endtask

  task automatic bpb_error(input logic [15:0] bps, input logic [7:0] spc, input logic [7:0] nfat,
                           input logic [31:0] flen, input logic [7:0] sig1, input logic [2:0] code);
    prep_bpb();
    build_bpb(bps, spc, 16'd32, nfat, flen, 32'd2, sig1);
    send_sector(512, -1, -1);
    @(negedge Clock);
    compared++;
    if (MountError !== 1'b1 || ErrorCode !== code || Mounted !== 1'b0) begin
      mismatched++;
      $display("FAIL bpb_check: Err=%b code=%0d, required 1/%0d", MountError, ErrorCode, code);
    end
  endtask

  task automatic test_bpb_errors();
    bpb_error(16'd512, 8'd8, 8'd2, 32'd961, 8'hAB, 3'd4);
    bpb_error(16'd1024, 8'd8, 8'd0, 32'd961, 8'hAA, 3'd5);
    bpb_error(16'd512, 8'd8, 8'd0, 32'd961, 8'hAA, 3'd6);
    bpb_error(16'd512, 8'd8, 8'd2, 32'd0, 8'hAA, 3'd6);
    bpb_error(16'd512, 8'd0, 8'd2, 32'd961, 8'hAA, 3'd6);
  endtask

  task automatic test_sd_error();
    prep_bpb();
    build_bpb(16'd512, 8'd8, 16'd32, 8'd2, 32'd961, 32'd2, 8'hAA);
    send_sector(101, 100, -1);
    compared++;
    if (MountError !== 1'b1 || ErrorCode !== 3'd1) begin
      mismatched++;
      $display("FAIL sd_error: Err=%b code=%0d, required 1/1", MountError, ErrorCode);
    end
    run_nominal();
    compared++;
    if (Mounted !== 1'b1 || MountError !== 1'b0 || FatStartSector !== 32'd8224 || RootDirSector !== 32'd10146) begin
      mismatched++;
      $display("FAIL sd_error_remount: Mounted=%b Err=%b fat=%0d root=%0d, required 1/0/8224/10146", Mounted, MountError, FatStartSector, RootDirSector);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] sec;
    start_mount();
    compared++;
    if (Mounted !== 1'b0 || MountBusy !== 1'b1 || RootDirSector !== 32'd0 || PartitionStartSector !== 32'd0) begin
      mismatched++;
      $display("FAIL restart_clear: Mounted=%b Busy=%b root=%0d part=%0d, required 0/1/0/0", Mounted, MountBusy, RootDirSector, PartitionStartSector);
    end
    wait_read(sec);
    build_mbr(8'h0B, 32'hFFFF_FF00, 8'hAA);
    send_sector(512, -1, -1);
    wait_read(sec);
    compared++;
    if (sec !== 32'hFFFF_FF00) begin
      mismatched++;
      $display("FAIL restart_bpb_lba: got %h, required ffffff00", sec);
    end
    build_bpb(16'd512, 8'd64, 16'h0200, 8'd3, 32'h6000_0000, 32'h00AB_CDEF, 8'hAA);
    send_sector(512, -1, -1);
    repeat (3) @(negedge Clock);
    compared++;
    if (FatStartSector !== 32'h0000_0100 || RootDirSector !== 32'h2000_0100) begin
      mismatched++;
      $display("FAIL wrap_addrs: fat=%h root=%h, required 00000100/20000100", FatStartSector, RootDirSector);
    end
    compared++;
    if (Mounted !== 1'b1 || SectorsPerCluster !== 8'd64 || RootCluster !== 32'h00AB_CDEF) begin
      mismatched++;
      $display("FAIL wrap_geom: Mounted=%b spc=%0d rcl=%h, required 1/64/00abcdef", Mounted, SectorsPerCluster, RootCluster);
    end
  endtask

  task automatic test_timeout();
    prep_bpb();
    build_bpb(16'd512, 8'd8, 16'd32, 8'd2, 32'd961, 32'd2, 8'hAA);
    send_sector(301, -1, -1);
    repeat (TO - 1) @(negedge Clock);
    compared++;
    if (MountError !== 1'b0) begin
      mismatched++;
      $display("FAIL timeout_early: Err=%b after %0d idle cycles, required 0", MountError, TO - 1);
    end
    @(negedge Clock);
    compared++;
    if (MountError !== 1'b1 || ErrorCode !== 3'd7) begin
      mismatched++;
      $display("FAIL timeout: Err=%b code=%0d after %0d idle cycles, required 1/7", MountError, ErrorCode, TO);
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    prep_bpb();
    build_bpb(16'd512, 8'd8, 16'd32, 8'd2, 32'd961, 32'd2, 8'hAA);
    send_sector(200, -1, -1);
    sys_rst_n = 1'b0;
    #1;
    compared++;
    if ({SdReadStart, MountBusy, Mounted, MountError, ErrorCode, SdReadSector, PartitionStartSector,
         FatStartSector, RootDirSector, SectorsPerCluster, RootCluster} !== '0) begin
      mismatched++;
      $display("FAIL reset_mid: Busy=%b part=%0d spc=%0d, required all 0", MountBusy, PartitionStartSector, SectorsPerCluster);
    end
    @(negedge Clock);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      SdByteValid = 1'b1;
      SdByte = 8'(i + 8'h40);
      @(negedge Clock);
      if (SdReadStart || MountBusy || Mounted || MountError) seen = 1'b1;
    end
    SdByteValid = 1'b0;
    compared++;
    if (seen || PartitionStartSector !== 32'd0 || SectorsPerCluster !== 8'd0) begin
      mismatched++;
      $display("FAIL reset_stray: activity=%b part=%0d spc=%0d, required 0/0/0", seen, PartitionStartSector, SectorsPerCluster);
    end
    run_nominal();
    compared++;
    if (Mounted !== 1'b1 || RootDirSector !== 32'd10146) begin
      mismatched++;
      $display("FAIL reset_remount: Mounted=%b root=%0d, required 1/10146", Mounted, RootDirSector);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_busy();
    test_mbr_errors();
    test_bpb_errors();
    test_sd_error();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
